lc3_control_fsm: RTL and testbench
==================================

# lc3_control_fsm

Multi-cycle sequencer for the LC-3 core: owns PC, IR and the NZP condition register and drives the Execution stage's ALU_CONTROL / ALU_MuxA / ALU_MuxB selects, register-file ports and a single shared memory port. Walks every instruction through FETCH, DECODE, EXEC and optional MEM/WB states. Sits between the memory interface and the Execution/register-file datapath.

## Interface
- RESET_PC, 16'h3000, PC value loaded at reset
- ALU_OP_ADD, 3'b000, ALU_CONTROL code for A+B
- ALU_OP_AND, 3'b001, ALU_CONTROL code for A&B
- ALU_OP_NOT, 3'b010, ALU_CONTROL code for ~A
- ALU_OP_PASSA, 3'b011, ALU_CONTROL code for Y=A

- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  synchronous reset, active-low
- MEM_RDY  in  1  memory completes the current request this cycle
- MEM_RDATA  in  16  read data, valid when MEM_RDY=1
- Y  in  16  ALU result from Execution
- NPZ_IN  in  3  ALU condition codes {N,Z,P} for Y
- RS2_DATA  in  16  register-file read port 2 data (store source)
- MEM_REQ, MEM_WE  out  1  memory request / write strobe
- MEM_ADDR, MEM_WDATA  out  16  request address / write data
- PC, IR  out  16  to Execution
- ALU_CONTROL  out  3;  ALU_MuxA  out  1;  ALU_MuxB  out  3
- RS1_ADDR, RS2_ADDR, RF_WADDR  out  3  register-file addresses
- RF_WE  out  1;  RF_WDATA  out  16
- NPZ  out  3  architectural condition register {N,Z,P}
- INSTR_DONE  out  1  one-cycle pulse on instruction retire
- HALT  out  1  illegal opcode seen; core stopped

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: MEM_REQ=1, MEM_WE=0, MEM_ADDR=PC; on MEM_RDY: IR<=MEM_RDATA, PC<=PC+1 (mod 2^16), -> DECODE.
- DECODE: one cycle. Supported opcodes IR[15:12]: ADD 0001, AND 0101, NOT 1001, BR 0000, LD 0010, ST 0011, JMP 1100, LEA 1110. Any other -> HALT.
- Decode always: RS1_ADDR=IR[8:6]; RS2_ADDR=IR[11:9] for ST else IR[2:0]; RF_WADDR=IR[11:9].
- EXEC selects (ALU_MuxB 000=RS2, 100=imm5, 110=off9):
  - ADD/AND: op ADD/AND, MuxA=1, MuxB=100 if IR[5] else 000; RF_WE=1, RF_WDATA=Y, NPZ<=NPZ_IN, -> FETCH.
  - NOT: op NOT, MuxA=1; write/NPZ as ADD.
  - LEA: op ADD, MuxA=0, MuxB=110; RF_WE=1, RF_WDATA=Y; NPZ unchanged; -> FETCH.
  - BR: op ADD, MuxA=0, MuxB=110; if (IR[11:9] & NPZ)!=0 then PC<=Y; -> FETCH. nzp=000 is a NOP.
  - JMP: op PASSA, MuxA=1; PC<=Y; -> FETCH.
  - LD/ST: op ADD, MuxA=0, MuxB=110; MAR<=Y; -> MEM.
- MEM: MEM_REQ=1, MEM_ADDR=MAR; ST: MEM_WE=1, MEM_WDATA=RS2_DATA, on MEM_RDY -> FETCH; LD: on MEM_RDY MDR<=MEM_RDATA -> WB.
- WB (LD): RF_WE=1, RF_WDATA=MDR; NPZ<=100 if MDR[15], 010 if MDR==0, else 001; -> FETCH.
- Outside EXEC, ALU_CONTROL/MuxA/MuxB = 0; RF_WE=1 only in EXEC (ADD/AND/NOT/LEA) and WB.
- INSTR_DONE=1 in the final cycle of each instruction (EXEC for non-memory ops, MEM for ST, WB for LD).
- HALT: sticky; HALT=1, no requests, RF_WE=0; leaves only on reset.

## Timing
- Reset (RST_N low at edge): state=FETCH, PC=RESET_PC, IR=0, NPZ=010, MAR=MDR=0; all strobes (MEM_REQ, MEM_WE, RF_WE, INSTR_DONE, HALT)=0 from the next cycle. Reset mid-request abandons it; MEM_REQ is 0 the cycle after.
- Memory handshake: MEM_REQ, MEM_ADDR, MEM_WE, MEM_WDATA are held stable until the edge where MEM_RDY=1; that edge completes the transfer. MEM_RDY while MEM_REQ=0 is ignored. Unbounded wait states are allowed.
- Zero-wait latency (MEM_RDY high whenever requested): ALU/LEA/BR/JMP = 3 cycles, ST = 4, LD = 5. Each memory wait state adds one cycle.
- PC seen by Execution in EXEC is the incremented PC, so offsets are relative to PC+1.
- PC wraps from 16'hFFFF to 16'h0000 with no flag.

## Test plan
- Reset then fetch ADD R1,R1,#-1 (16'h127F) with R1=0, zero-wait -> RF_WE with RF_WDATA=16'hFFFF, NPZ=100, PC=16'h3001, INSTR_DONE in cycle 3.
- LD R2 at PC=16'h3000, off9=+4, MEM_RDATA=16'h0000, 2 wait states on data read -> MEM_ADDR=16'h3005, WB writes R2=0, NPZ=010, 7 cycles total.
- ST R3 (RS2_DATA=16'hBEEF), off9=-1 at PC=16'h3000 -> MEM_WE=1, MEM_ADDR=16'h3000, MEM_WDATA=16'hBEEF held until MEM_RDY.
- BRz +2 with NPZ=010 -> PC=16'h3003; same with NPZ=001 -> PC=16'h3001; BR nzp=000 -> not taken.
- Opcode 1111 -> HALT=1, MEM_REQ stays 0 for 10 cycles; RST_N low one cycle -> HALT=0, PC=16'h3000, fetch resumes.
- RST_N asserted while FETCH waits on MEM_RDY, PC at 16'hFFFF -> PC=RESET_PC, MEM_REQ drops; separately, fetch at 16'hFFFF -> PC wraps to 16'h0000.

Source files
------------

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: multi-cycle LC-3 sequencer owning PC, IR and NZP.
// Walks each instruction through FETCH/DECODE/EXEC and optional MEM/WB.
module lc3_control_fsm #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MEM_RDY,
  input  logic [15:0] MEM_RDATA,
  input  logic [15:0] Y,
  input  logic [2:0]  NPZ_IN,
  input  logic [15:0] RS2_DATA,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic [2:0]  ALU_CONTROL,
  output logic        ALU_MuxA,
  output logic [2:0]  ALU_MuxB,
  output logic [2:0]  RS1_ADDR,
  output logic [2:0]  RS2_ADDR,
  output logic [2:0]  RF_WADDR,
  output logic        RF_WE,
  output logic [15:0] RF_WDATA,
  output logic [2:0]  NPZ,
  output logic        INSTR_DONE,
  output logic        HALT
);

  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_AND   = 3'b001;
  localparam logic [2:0] ALU_OP_NOT   = 3'b010;
  localparam logic [2:0] ALU_OP_PASSA = 3'b011;

  localparam logic [2:0] MUXB_RS2  = 3'b000;
  localparam logic [2:0] MUXB_IMM5 = 3'b100;
  localparam logic [2:0] MUXB_OFF9 = 3'b110;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  npz_q, npz_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;

  logic        mem_req, mem_we, rf_we, done, halt;
  logic [15:0] mem_addr, mem_wdata, rf_wdata;
  logic [2:0]  alu_ctl, alu_mxb;
  logic        alu_mxa;

  logic [3:0] opc;
  logic is_br, is_add, is_ld, is_st;
  logic is_and, is_not, is_jmp, is_lea;
  logic legal;

  assign opc    = ir_q[15:12];
  assign is_br  = (opc == 4'b0000);
  assign is_add = (opc == 4'b0001);
  assign is_ld  = (opc == 4'b0010);
  assign is_st  = (opc == 4'b0011);
  assign is_and = (opc == 4'b0101);
  assign is_not = (opc == 4'b1001);
  assign is_jmp = (opc == 4'b1100);
  assign is_lea = (opc == 4'b1110);
  assign legal  = |{is_br, is_add, is_ld, is_st,
                    is_and, is_not, is_jmp, is_lea};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    npz_d     = npz_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = 16'h0000;
    alu_ctl   = ALU_OP_ADD;
    alu_mxa   = 1'b0;
    alu_mxb   = MUXB_RS2;
    rf_we     = 1'b0;
    rf_wdata  = Y;
    done      = 1'b0;
    halt      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (MEM_RDY) begin
          ir_d    = MEM_RDATA;
          pc_d    = pc_q + 16'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        done    = ~(is_ld | is_st);
        unique case (1'b1)
          is_add, is_and: begin
            alu_ctl = is_and ? ALU_OP_AND : ALU_OP_ADD;
            alu_mxa = 1'b1;
            alu_mxb = ir_q[5] ? MUXB_IMM5 : MUXB_RS2;
            rf_we   = 1'b1;
            npz_d   = NPZ_IN;
          end
          is_not: begin
            alu_ctl = ALU_OP_NOT;
            alu_mxa = 1'b1;
            rf_we   = 1'b1;
            npz_d   = NPZ_IN;
          end
          is_lea: begin
            alu_mxb = MUXB_OFF9;
            rf_we   = 1'b1;
          end
          is_br: begin
            alu_mxb = MUXB_OFF9;
            if (|(ir_q[11:9] & npz_q)) pc_d = Y;
          end
          is_jmp: begin
            alu_ctl = ALU_OP_PASSA;
            alu_mxa = 1'b1;
            pc_d    = Y;
          end
          is_ld, is_st: begin
            alu_mxb = MUXB_OFF9;
            mar_d   = Y;
            state_d = S_MEM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = mar_q;
        if (is_st) begin
          mem_we    = 1'b1;
          mem_wdata = RS2_DATA;
          if (MEM_RDY) begin
            done    = 1'b1;
            state_d = S_FETCH;
          end
        end else if (MEM_RDY) begin
          mdr_d   = MEM_RDATA;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        done     = 1'b1;
        state_d  = S_FETCH;
        if (mdr_q[15])              npz_d = 3'b100;
        else if (mdr_q == 16'h0000) npz_d = 3'b010;
        else                        npz_d = 3'b001;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      npz_q   <= 3'b010;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npz_q   <= npz_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Strobes are masked while reset is held so a pending request is dropped.
  assign MEM_REQ    = RST_N & mem_req;
  assign MEM_WE     = RST_N & mem_we;
  assign RF_WE      = RST_N & rf_we;
  assign INSTR_DONE = RST_N & done;
  assign HALT       = RST_N & halt;

  assign MEM_ADDR    = mem_addr;
  assign MEM_WDATA   = mem_wdata;
  assign PC          = pc_q;
  assign IR          = ir_q;
  assign ALU_CONTROL = alu_ctl;
  assign ALU_MuxA    = alu_mxa;
  assign ALU_MuxB    = alu_mxb;
  assign RS1_ADDR    = ir_q[8:6];
  assign RS2_ADDR    = is_st ? ir_q[11:9] : ir_q[2:0];
  assign RF_WADDR    = ir_q[11:9];
  assign RF_WDATA    = rf_wdata;
  assign NPZ         = npz_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: directed checks of the LC-3 control sequencer.
// The bench plays memory and ALU, driving hand-computed Y / NPZ_IN.
module tb_lc3_control_fsm;

  logic        CLK;
  logic        RST_N;
  logic        MEM_RDY;
  logic [15:0] MEM_RDATA;
  logic [15:0] Y;
  logic [2:0]  NPZ_IN;
  logic [15:0] RS2_DATA;
  logic        MEM_REQ, MEM_WE;
  logic [15:0] MEM_ADDR, MEM_WDATA;
  logic [15:0] PC, IR;
  logic [2:0]  ALU_CONTROL;
  logic        ALU_MuxA;
  logic [2:0]  ALU_MuxB;
  logic [2:0]  RS1_ADDR, RS2_ADDR, RF_WADDR;
  logic        RF_WE;
  logic [15:0] RF_WDATA;
  logic [2:0]  NPZ;
  logic        INSTR_DONE, HALT;

  int n_cmp = 0;
  int n_bad = 0;

  lc3_control_fsm dut (
    .CLK(CLK), .RST_N(RST_N),
    .MEM_RDY(MEM_RDY), .MEM_RDATA(MEM_RDATA),
    .Y(Y), .NPZ_IN(NPZ_IN), .RS2_DATA(RS2_DATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .PC(PC), .IR(IR),
    .ALU_CONTROL(ALU_CONTROL), .ALU_MuxA(ALU_MuxA),
    .ALU_MuxB(ALU_MuxB),
    .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
    .RF_WADDR(RF_WADDR), .RF_WE(RF_WE),
    .RF_WDATA(RF_WDATA), .NPZ(NPZ),
    .INSTR_DONE(INSTR_DONE), .HALT(HALT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ALU op table: instr, Y, NPZ_IN, {ctl,muxA,muxB}, rs2, npz after
  localparam logic [15:0] T_INS [4] =
    '{16'h5283, 16'h52A5, 16'h997F, 16'hE5FE};
  localparam logic [15:0] T_Y [4] =
    '{16'h00F0, 16'h0000, 16'h8000, 16'h3002};
  localparam logic [2:0] T_NZ [4] =
    '{3'b001, 3'b010, 3'b100, 3'b001};
  localparam logic [6:0] T_SEL [4] =
    '{7'b001_1_000, 7'b001_1_100, 7'b010_1_000, 7'b000_0_110};
  localparam logic [2:0] T_RS2 [4] =
    '{3'd3, 3'd5, 3'd7, 3'd6};
  localparam logic [2:0] T_NPZ [4] =
    '{3'b001, 3'b010, 3'b100, 3'b100};

  task automatic step(input logic rdy, input logic [15:0] rd,
                      input logic [15:0] yv, input logic [2:0] nz);
    @(negedge CLK);
    MEM_RDY   = rdy;
    MEM_RDATA = rd;
    Y         = yv;
    NPZ_IN    = nz;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N   = 1'b0;
    MEM_RDY = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    #1;
    n_cmp++;
    if ({PC, IR} !== {16'h3000, 16'h0000}) begin
      n_bad++;
      $display("FAIL rst_pc_ir: got %h want %h", {PC, IR}, {16'h3000, 16'h0000});
    end
    n_cmp++;
    if (NPZ !== 3'b010) begin
      n_bad++;
      $display("FAIL rst_npz: got %b want 010", NPZ);
    end
    n_cmp++;
    if ({MEM_REQ, MEM_WE, RF_WE, INSTR_DONE, HALT} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_strobes: got %b want 00000",
               {MEM_REQ, MEM_WE, RF_WE, INSTR_DONE, HALT});
    end
    RST_N = 1'b1;
    #1;
    n_cmp++;
    if ({MEM_REQ, MEM_WE, MEM_ADDR} !== {2'b10, 16'h3000}) begin
      n_bad++;
      $display("FAIL rst_fetch: got %h want %h",
               {MEM_REQ, MEM_WE, MEM_ADDR}, {2'b10, 16'h3000});
    end
  endtask

  task automatic test_add();
    step(1'b1, 16'h127F, 16'h0, 3'b0);
    n_cmp++;
    if ({MEM_REQ, MEM_WE, MEM_ADDR, INSTR_DONE} !== {2'b10, 16'h3000, 1'b0}) begin
      n_bad++;
      $display("FAIL add_fetch: got %h want %h",
               {MEM_REQ, MEM_WE, MEM_ADDR, INSTR_DONE}, {2'b10, 16'h3000, 1'b0});
    end
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({PC, IR} !== {16'h3001, 16'h127F}) begin
      n_bad++;
      $display("FAIL add_dec_pcir: got %h want %h", {PC, IR}, {16'h3001, 16'h127F});
    end
    n_cmp++;
    if ({RS1_ADDR, RS2_ADDR, RF_WADDR, MEM_REQ, RF_WE, INSTR_DONE}
        !== {3'd1, 3'd7, 3'd1, 3'b000}) begin
      n_bad++;
      $display("FAIL add_dec_ports: got %b want %b",
               {RS1_ADDR, RS2_ADDR, RF_WADDR, MEM_REQ, RF_WE, INSTR_DONE},
               {3'd1, 3'd7, 3'd1, 3'b000});
    end
    step(1'b0, 16'h0, 16'hFFFF, 3'b100);
    n_cmp++;
    if ({RF_WE, RF_WDATA, INSTR_DONE, PC} !== {1'b1, 16'hFFFF, 1'b1, 16'h3001}) begin
      n_bad++;
      $display("FAIL add_exec: got %h want %h", {RF_WE, RF_WDATA, INSTR_DONE, PC},
               {1'b1, 16'hFFFF, 1'b1, 16'h3001});
    end
    n_cmp++;
    if ({ALU_CONTROL, ALU_MuxA, ALU_MuxB} !== 7'b000_1_100) begin
      n_bad++;
      $display("FAIL add_sel: got %b want 0001100", {ALU_CONTROL, ALU_MuxA, ALU_MuxB});
    end
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({NPZ, MEM_REQ, MEM_ADDR, INSTR_DONE, RF_WE}
        !== {3'b100, 1'b1, 16'h3001, 2'b00}) begin
      n_bad++;
      $display("FAIL add_after: got %h want %h",
               {NPZ, MEM_REQ, MEM_ADDR, INSTR_DONE, RF_WE},
               {3'b100, 1'b1, 16'h3001, 2'b00});
    end
  endtask

  task automatic test_alu_ops();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, T_INS[i], 16'h0, 3'b0);
      step(1'b0, 16'h0, 16'h0, 3'b0);
      n_cmp++;
      if (RS2_ADDR !== T_RS2[i]) begin
        n_bad++;
        $display("FAIL alu%0d_rs2: got %0d want %0d", i, RS2_ADDR, T_RS2[i]);
      end
      step(1'b0, 16'h0, T_Y[i], T_NZ[i]);
      n_cmp++;
      if ({ALU_CONTROL, ALU_MuxA, ALU_MuxB} !== T_SEL[i]) begin
        n_bad++;
        $display("FAIL alu%0d_sel: got %b want %b", i,
                 {ALU_CONTROL, ALU_MuxA, ALU_MuxB}, T_SEL[i]);
      end
      n_cmp++;
      if ({RF_WE, RF_WDATA, INSTR_DONE} !== {1'b1, T_Y[i], 1'b1}) begin
        n_bad++;
        $display("FAIL alu%0d_wr: got %h want %h", i,
                 {RF_WE, RF_WDATA, INSTR_DONE}, {1'b1, T_Y[i], 1'b1});
      end
      step(1'b0, 16'h0, 16'h0, 3'b0);
      n_cmp++;
      if ({NPZ, MEM_ADDR} !== {T_NPZ[i], 16'h3001 + 16'(i)}) begin
        n_bad++;
        $display("FAIL alu%0d_npz_pc: got %h want %h", i,
                 {NPZ, MEM_ADDR}, {T_NPZ[i], 16'h3001 + 16'(i)});
      end
    end
  endtask

  task automatic test_ld();
    do_reset();
    step(1'b1, 16'h2404, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if (RF_WADDR !== 3'd2) begin
      n_bad++;
      $display("FAIL ld_waddr: got %0d want 2", RF_WADDR);
    end
    step(1'b0, 16'h0, 16'h3005, 3'b0);
    n_cmp++;
    if ({ALU_CONTROL, ALU_MuxA, ALU_MuxB, RF_WE, INSTR_DONE, MEM_REQ}
        !== 10'b000_0_110_000) begin
      n_bad++;
      $display("FAIL ld_exec: got %b want 0000110000",
               {ALU_CONTROL, ALU_MuxA, ALU_MuxB, RF_WE, INSTR_DONE, MEM_REQ});
    end
    for (int w = 0; w < 3; w++) begin
      step(w == 2, 16'h0000, 16'h0, 3'b0);
      n_cmp++;
      if ({MEM_REQ, MEM_WE, MEM_ADDR, INSTR_DONE} !== {2'b10, 16'h3005, 1'b0}) begin
        n_bad++;
        $display("FAIL ld_mem%0d: got %h want %h", w,
                 {MEM_REQ, MEM_WE, MEM_ADDR, INSTR_DONE}, {2'b10, 16'h3005, 1'b0});
      end
    end
    step(1'b0, 16'hAAAA, 16'h0, 3'b0);
    n_cmp++;
    if ({RF_WE, RF_WDATA, RF_WADDR, INSTR_DONE, MEM_REQ}
        !== {1'b1, 16'h0000, 3'd2, 2'b10}) begin
      n_bad++;
      $display("FAIL ld_wb: got %h want %h",
               {RF_WE, RF_WDATA, RF_WADDR, INSTR_DONE, MEM_REQ},
               {1'b1, 16'h0000, 3'd2, 2'b10});
    end
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({NPZ, MEM_REQ, MEM_ADDR} !== {3'b010, 1'b1, 16'h3001}) begin
      n_bad++;
      $display("FAIL ld_after: got %h want %h",
               {NPZ, MEM_REQ, MEM_ADDR}, {3'b010, 1'b1, 16'h3001});
    end
    // zero-wait load of a negative value: five cycles, NPZ -> 100
    step(1'b1, 16'h2404, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h3006, 3'b0);
    step(1'b1, 16'h8001, 16'h0, 3'b0);
    n_cmp++;
    if ({MEM_ADDR, INSTR_DONE} !== {16'h3006, 1'b0}) begin
      n_bad++;
      $display("FAIL ld2_mem: got %h want %h", {MEM_ADDR, INSTR_DONE}, {16'h3006, 1'b0});
    end
    step(1'b0, 16'h0000, 16'h0, 3'b0);
    n_cmp++;
    if ({RF_WE, RF_WDATA, INSTR_DONE} !== {1'b1, 16'h8001, 1'b1}) begin
      n_bad++;
      $display("FAIL ld2_wb: got %h want %h",
               {RF_WE, RF_WDATA, INSTR_DONE}, {1'b1, 16'h8001, 1'b1});
    end
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({NPZ, MEM_ADDR} !== {3'b100, 16'h3002}) begin
      n_bad++;
      $display("FAIL ld2_after: got %h want %h", {NPZ, MEM_ADDR}, {3'b100, 16'h3002});
    end
  endtask

  task automatic test_st();
    do_reset();
    RS2_DATA = 16'hBEEF;
    step(1'b1, 16'h37FF, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({RS1_ADDR, RS2_ADDR} !== {3'd7, 3'd3}) begin
      n_bad++;
      $display("FAIL st_dec: got %b want 111011", {RS1_ADDR, RS2_ADDR});
    end
    step(1'b0, 16'h0, 16'h3000, 3'b0);
    n_cmp++;
    if ({ALU_MuxA, ALU_MuxB, RF_WE, INSTR_DONE} !== 6'b0_110_00) begin
      n_bad++;
      $display("FAIL st_exec: got %b want 011000",
               {ALU_MuxA, ALU_MuxB, RF_WE, INSTR_DONE});
    end
    for (int w = 0; w < 4; w++) begin
      step(w == 3, 16'h0, 16'h0, 3'b0);
      n_cmp++;
      if ({MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, INSTR_DONE, RF_WE}
          !== {2'b11, 16'h3000, 16'hBEEF, w == 3, 1'b0}) begin
        n_bad++;
        $display("FAIL st_mem%0d: got %h want %h", w,
                 {MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, INSTR_DONE, RF_WE},
                 {2'b11, 16'h3000, 16'hBEEF, w == 3, 1'b0});
      end
    end
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({MEM_REQ, MEM_WE, MEM_ADDR, INSTR_DONE} !== {2'b10, 16'h3001, 1'b0}) begin
      n_bad++;
      $display("FAIL st_after: got %h want %h",
               {MEM_REQ, MEM_WE, MEM_ADDR, INSTR_DONE}, {2'b10, 16'h3001, 1'b0});
    end
  endtask

  task automatic test_br();
    do_reset();
    // BRz +2, NPZ=010: taken
    step(1'b1, 16'h0402, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h3003, 3'b0);
    n_cmp++;
    if ({PC, ALU_CONTROL, ALU_MuxA, ALU_MuxB, INSTR_DONE, RF_WE}
        !== {16'h3001, 7'b000_0_110, 2'b10}) begin
      n_bad++;
      $display("FAIL brz_exec: got %h want %h",
               {PC, ALU_CONTROL, ALU_MuxA, ALU_MuxB, INSTR_DONE, RF_WE},
               {16'h3001, 7'b000_0_110, 2'b10});
    end
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({PC, MEM_ADDR} !== {16'h3003, 16'h3003}) begin
      n_bad++;
      $display("FAIL brz_taken: got %h want 30033003", {PC, MEM_ADDR});
    end
    // ADD sets NPZ=001, then BRz +2 from 3004 is not taken
    step(1'b1, 16'h127F, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0001, 3'b001);
    step(1'b1, 16'h0402, 16'h0, 3'b0);
    n_cmp++;
    if (NPZ !== 3'b001) begin
      n_bad++;
      $display("FAIL br_npz: got %b want 001", NPZ);
    end
    step(1'b0, 16'h0, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h3007, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if (PC !== 16'h3005) begin
      n_bad++;
      $display("FAIL brz_not_taken: got %h want 3005", PC);
    end
    // BR nzp=000 is a NOP
    step(1'b1, 16'h0002, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h3008, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if (PC !== 16'h3006) begin
      n_bad++;
      $display("FAIL br_nop: got %h want 3006", PC);
    end
    // BRp +2 with NPZ=001: taken
    step(1'b1, 16'h0202, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h3009, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if (PC !== 16'h3009) begin
      n_bad++;
      $display("FAIL brp_taken: got %h want 3009", PC);
    end
  endtask

  task automatic test_jmp_wrap();
    do_reset();
    step(1'b1, 16'hC080, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if (RS1_ADDR !== 3'd2) begin
      n_bad++;
      $display("FAIL jmp_rs1: got %0d want 2", RS1_ADDR);
    end
    step(1'b0, 16'h0, 16'hFFFF, 3'b0);
    n_cmp++;
    if ({ALU_CONTROL, ALU_MuxA, INSTR_DONE, RF_WE} !== 6'b011_1_10) begin
      n_bad++;
      $display("FAIL jmp_exec: got %b want 011110",
               {ALU_CONTROL, ALU_MuxA, INSTR_DONE, RF_WE});
    end
    step(1'b0, 16'h0, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({PC, MEM_REQ, MEM_ADDR} !== {16'hFFFF, 1'b1, 16'hFFFF}) begin
      n_bad++;
      $display("FAIL jmp_fetch_wait: got %h want %h",
               {PC, MEM_REQ, MEM_ADDR}, {16'hFFFF, 1'b1, 16'hFFFF});
    end
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (MEM_REQ !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_abort_req: got %b want 0", MEM_REQ);
    end
    @(negedge CLK);
    #1;
    n_cmp++;
    if ({PC, MEM_REQ} !== {16'h3000, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_abort_pc: got %h want %h", {PC, MEM_REQ}, {16'h3000, 1'b0});
    end
    RST_N = 1'b1;
    #1;
    n_cmp++;
    if ({MEM_REQ, MEM_ADDR} !== {1'b1, 16'h3000}) begin
      n_bad++;
      $display("FAIL rst_abort_resume: got %h want %h",
               {MEM_REQ, MEM_ADDR}, {1'b1, 16'h3000});
    end
    // fetch at FFFF wraps PC to 0000
    step(1'b1, 16'hC080, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'hFFFF, 3'b0);
    step(1'b1, 16'h0000, 16'h0, 3'b0);
    n_cmp++;
    if (MEM_ADDR !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_fetch: got %h want ffff", MEM_ADDR);
    end
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({PC, IR} !== {16'h0000, 16'h0000}) begin
      n_bad++;
      $display("FAIL wrap_pc: got %h want 00000000", {PC, IR});
    end
    step(1'b0, 16'h0, 16'h0001, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({PC, MEM_ADDR} !== {16'h0000, 16'h0000}) begin
      n_bad++;
      $display("FAIL wrap_nop: got %h want 00000000", {PC, MEM_ADDR});
    end
  endtask

  task automatic test_halt();
    int bad_cycles;
    do_reset();
    step(1'b1, 16'hF025, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if (HALT !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_decode: got %b want 0", HALT);
    end
    bad_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 16'h1234, 16'h5555, 3'b001);
      if ({HALT, MEM_REQ, MEM_WE, RF_WE, INSTR_DONE} !== 5'b10000)
        bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++;
      $display("FAIL halt_sticky: got %0d bad cycles want 0", bad_cycles);
    end
    n_cmp++;
    if (PC !== 16'h3001) begin
      n_bad++;
      $display("FAIL halt_pc: got %h want 3001", PC);
    end
    @(negedge CLK);
    RST_N   = 1'b0;
    MEM_RDY = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    n_cmp++;
    if ({HALT, PC, MEM_REQ, MEM_ADDR} !== {1'b0, 16'h3000, 1'b1, 16'h3000}) begin
      n_bad++;
      $display("FAIL halt_reset: got %h want %h", {HALT, PC, MEM_REQ, MEM_ADDR},
               {1'b0, 16'h3000, 1'b1, 16'h3000});
    end
    step(1'b1, 16'h127F, 16'h0, 3'b0);
    step(1'b0, 16'h0, 16'h0, 3'b0);
    n_cmp++;
    if ({HALT, IR, PC} !== {1'b0, 16'h127F, 16'h3001}) begin
      n_bad++;
      $display("FAIL halt_resume: got %h want %h",
               {HALT, IR, PC}, {1'b0, 16'h127F, 16'h3001});
    end
  endtask

  initial begin
    RST_N     = 1'b0;
    MEM_RDY   = 1'b0;
    MEM_RDATA = 16'h0;
    Y         = 16'h0;
    NPZ_IN    = 3'b0;
    RS2_DATA  = 16'h0;
    test_reset();
    test_add();
    test_alu_ops();
    test_ld();
    test_st();
    test_br();
    test_jmp_wrap();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
